// File: rtl/conv_pkg.sv
// Shared types and constants for the two-layer convolution sequencer.
// The state encoding is plain logic constants so the state register can be probed as a raw 3-bit value.
package conv_pkg;

   localparam int CONV_DIM_W = 8;
   localparam int TIMER_W    = 16;

   localparam logic [CONV_DIM_W-1:0] DEF_X_DIM = 8'd16;
   localparam logic [CONV_DIM_W-1:0] DEF_Y_DIM = 8'd4;
   localparam logic [CONV_DIM_W-1:0] DEF_Z_DIM = 8'd13;

   typedef logic [2:0] conv_state_t;

   localparam conv_state_t S_IDLE   = 3'd0;
   localparam conv_state_t S_MEM_L1 = 3'd1;
   localparam conv_state_t S_PE_L1  = 3'd2;
   localparam conv_state_t S_WR_L2  = 3'd3;
   localparam conv_state_t S_MEM_L2 = 3'd4;
   localparam conv_state_t S_PE_L2  = 3'd5;
   localparam conv_state_t S_DONE   = 3'd6;
   localparam conv_state_t S_ERR    = 3'd7;

   // States in which a start request is accepted.
   function automatic logic can_start(conv_state_t s);
      return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
   endfunction

endpackage

// File: rtl/conv_ctrl_if.sv
// Handshake and dimension bus between the sequencer (master) and the convolution datapath (slave).
interface conv_ctrl_if;
   import conv_pkg::*;

   logic                  start_mem_l1;
   logic                  start_pe_l1;
   logic                  wrmem_en_l2;
   logic                  start_mem_l2;
   logic                  start_pe_l2;
   logic                  done_mem_l1;
   logic                  done_pe_l1;
   logic                  done_mem_l2;
   logic                  done_pe_l2;
   logic [CONV_DIM_W-1:0] x;
   logic [CONV_DIM_W-1:0] y;
   logic [CONV_DIM_W-1:0] z;

   modport master (
      output start_mem_l1, start_pe_l1, wrmem_en_l2, start_mem_l2, start_pe_l2, x, y, z,
      input  done_mem_l1, done_pe_l1, done_mem_l2, done_pe_l2
   );

   modport slave (
      input  start_mem_l1, start_pe_l1, wrmem_en_l2, start_mem_l2, start_pe_l2, x, y, z,
      output done_mem_l1, done_pe_l1, done_mem_l2, done_pe_l2
   );

endinterface

// File: rtl/conv_wait_timer.sv
// Per-state wait counter: cleared on every state entry, saturates at all-ones, and flags when it sits on term.
module conv_wait_timer
   import conv_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [W-1:0] term,
   output logic         hit
);

   logic [W-1:0] cnt;

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (cnt != '1) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign hit = (cnt == term);

endmodule

// File: rtl/conv_ctrl.sv
// Run sequencer for the two-layer convolution datapath: L1 load, L1 compute, L1->L2 write-back,
// L2 load, L2 compute, with per-state timeout, latched dimension config and a run cycle counter.
module conv_ctrl
   import conv_pkg::*;
#(
   parameter logic [CONV_DIM_W-1:0] DEF_X     = DEF_X_DIM,
   parameter logic [CONV_DIM_W-1:0] DEF_Y     = DEF_Y_DIM,
   parameter logic [CONV_DIM_W-1:0] DEF_Z     = DEF_Z_DIM,
   parameter int                    WR_CYCLES = 1,
   parameter int                    TIMEOUT   = 65535
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CONV_DIM_W-1:0] cfg_x,
   input  logic [CONV_DIM_W-1:0] cfg_y,
   input  logic [CONV_DIM_W-1:0] cfg_z,
   conv_ctrl_if.master           dp,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [31:0]           cycles
);

   localparam logic [TIMER_W-1:0] TO_TERM = TIMER_W'(TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] WR_TERM = TIMER_W'(WR_CYCLES - 1);

   conv_state_t        state;
   conv_state_t        next_state;
   logic               accept;
   logic               finishing;
   logic               hit;
   logic [TIMER_W-1:0] term;

   assign accept    = start && can_start(state);
   assign finishing = (next_state == S_DONE || next_state == S_ERR) && !can_start(state);
   assign term      = (state == S_WR_L2) ? WR_TERM : TO_TERM;

   conv_wait_timer #(.W(TIMER_W)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (next_state != state),
      .term (term),
      .hit  (hit)
   );

   // A done seen while its start pulse is still high is left over from the previous run.
   // Done is tested before the timeout so a done on the timeout cycle still advances.
   // NOTE: next_state gets a default first so no path through the case infers a latch.
   always_comb begin
      next_state = state;
      case (state)
         S_MEM_L1: if (dp.done_mem_l1 && !dp.start_mem_l1) next_state = S_PE_L1;
                   else if (hit)                           next_state = S_ERR;
         S_PE_L1:  if (dp.done_pe_l1 && !dp.start_pe_l1)   next_state = S_WR_L2;
                   else if (hit)                           next_state = S_ERR;
         S_WR_L2:  if (hit)                                next_state = S_MEM_L2;
         S_MEM_L2: if (dp.done_mem_l2 && !dp.start_mem_l2) next_state = S_PE_L2;
                   else if (hit)                           next_state = S_ERR;
         S_PE_L2:  if (dp.done_pe_l2 && !dp.start_pe_l2)   next_state = S_DONE;
                   else if (hit)                           next_state = S_ERR;
         default:  if (accept)                             next_state = S_MEM_L1;
      endcase
   end

   // The dimension registers take their defaults on reset because the datapath reads them while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         dp.start_mem_l1 <= 1'b0;
         dp.start_pe_l1  <= 1'b0;
         dp.wrmem_en_l2  <= 1'b0;
         dp.start_mem_l2 <= 1'b0;
         dp.start_pe_l2  <= 1'b0;
         dp.x            <= DEF_X;
         dp.y            <= DEF_Y;
         dp.z            <= DEF_Z;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
         cycles          <= '0;
      end else begin
         state           <= next_state;
         dp.start_mem_l1 <= (next_state == S_MEM_L1) && (state != S_MEM_L1);
         dp.start_pe_l1  <= (next_state == S_PE_L1)  && (state != S_PE_L1);
         dp.wrmem_en_l2  <= (next_state == S_WR_L2);
         dp.start_mem_l2 <= (next_state == S_MEM_L2) && (state != S_MEM_L2);
         dp.start_pe_l2  <= (next_state == S_PE_L2)  && (state != S_PE_L2);
         if (accept) begin
            dp.x   <= cfg_x;
            dp.y   <= cfg_y;
            dp.z   <= cfg_z;
            busy   <= 1'b1;
            done   <= 1'b0;
            error  <= 1'b0;
            cycles <= '0;
         end else begin
            // The edge that closes the run is not counted.
            if (busy && !finishing && cycles != '1) cycles <= cycles + 1'b1;
            if (finishing) busy <= 1'b0;
            if (finishing && next_state == S_DONE) done  <= 1'b1;
            if (finishing && next_state == S_ERR)  error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_conv_ctrl.sv
// Scoreboard bench for conv_ctrl: expected output events are queued at stimulus time and
// a negedge monitor pops and compares each event the DUT presents.
module tb_conv_ctrl;

   typedef enum {EV_MEM_L1, EV_PE_L1, EV_MEM_L2, EV_PE_L2, EV_WR,
                 EV_DONE, EV_ERR, EV_DONE_CLR, EV_ERR_CLR} ev_kind_t;

   typedef struct {
      ev_kind_t    kind;
      int          t;
      logic [31:0] val;
      logic [23:0] xyz;
      logic        busy;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst, rst_b, start, start_b;
   logic [7:0]  cfg_x, cfg_y, cfg_z, cfg_bx, cfg_by, cfg_bz;
   logic        busy_a, done_a, error_a, busy_b, done_b, error_b;
   logic [31:0] cycles_a, cycles_b;
   logic [3:0]  done_vec, hold, never;
   int          tick = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   ev_t         exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) tick <= tick + 1;

   conv_ctrl_if bus_a ();
   conv_ctrl_if bus_b ();

   assign bus_a.done_mem_l1 = done_vec[0];
   assign bus_a.done_pe_l1  = done_vec[1];
   assign bus_a.done_mem_l2 = done_vec[2];
   assign bus_a.done_pe_l2  = done_vec[3];
   assign bus_b.done_mem_l1 = 1'b1;
   assign bus_b.done_pe_l1  = 1'b1;
   assign bus_b.done_mem_l2 = 1'b1;
   assign bus_b.done_pe_l2  = 1'b1;

   wire [3:0] pulse_a = {bus_a.start_pe_l2, bus_a.start_mem_l2, bus_a.start_pe_l1, bus_a.start_mem_l1};

   conv_ctrl #(.WR_CYCLES(1), .TIMEOUT(20)) dut_a (
      .clk(clk), .rst(rst), .start(start), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_z(cfg_z),
      .dp(bus_a), .busy(busy_a), .done(done_a), .error(error_a), .cycles(cycles_a)
   );

   conv_ctrl #(.WR_CYCLES(4), .TIMEOUT(20)) dut_b (
      .clk(clk), .rst(rst_b), .start(start_b), .cfg_x(cfg_bx), .cfg_y(cfg_by), .cfg_z(cfg_bz),
      .dp(bus_b), .busy(busy_b), .done(done_b), .error(error_b), .cycles(cycles_b)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic expect_ev(input ev_kind_t k, input int t, input logic [31:0] v,
                            input logic [23:0] xyz, input logic b);
      ev_t e;
      e.kind = k; e.t = t; e.val = v; e.xyz = xyz; e.busy = b;
      exp_q.push_back(e);
   endtask

   // Normal run with 5-cycle done responses; pe1_len is the PE_L1 stay, clr selects the flag cleared at start.
   task automatic expect_run(input int b, input logic [23:0] xyz, input int clr, input int pe1_len);
      expect_ev(EV_MEM_L1, b, 0, xyz, 1'b1);
      if (clr == 1) expect_ev(EV_DONE_CLR, b, 0, xyz, 1'b1);
      if (clr == 2) expect_ev(EV_ERR_CLR, b, 0, xyz, 1'b1);
      expect_ev(EV_PE_L1,  b + 6,            0, xyz, 1'b1);
      expect_ev(EV_WR,     b + 6 + pe1_len,  1, xyz, 1'b1);
      expect_ev(EV_MEM_L2, b + 7 + pe1_len,  0, xyz, 1'b1);
      expect_ev(EV_PE_L2,  b + 13 + pe1_len, 0, xyz, 1'b1);
      expect_ev(EV_DONE,   b + 19 + pe1_len, 32'(18 + pe1_len), xyz, 1'b0);
   endtask

   task automatic emit(input ev_kind_t k, input int t, input logic [31:0] v);
      ev_t got, want;
      got.kind = k; got.t = t; got.val = v;
      got.xyz = {bus_a.x, bus_a.y, bus_a.z}; got.busy = busy_a;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event: got %s at t=%0d val=%0d, expected none", k.name(), t, v);
      end else begin
         want = exp_q.pop_front();
         if (got.kind != want.kind || got.t != want.t || got.val !== want.val ||
             got.xyz !== want.xyz || got.busy !== want.busy) begin
            n_fail++;
            $display("FAIL event_%s: got %s t=%0d val=%0d xyz=%h busy=%b, expected %s t=%0d val=%0d xyz=%h busy=%b",
                     want.kind.name(), got.kind.name(), got.t, got.val, got.xyz, got.busy,
                     want.kind.name(), want.t, want.val, want.xyz, want.busy);
         end
      end
   endtask

   task automatic wait_until(input int t);
      while (tick < t) @(negedge clk);
   endtask

   initial begin
      int base;
      rst = 1'b1; rst_b = 1'b1; start = 1'b0; start_b = 1'b0;
      {cfg_x, cfg_y, cfg_z} = '0; {cfg_bx, cfg_by, cfg_bz} = '0;
      hold = '0; never = '0; done_vec = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0; rst_b = 1'b0;
      @(negedge clk);

      check("reset_x", 32'(bus_a.x), 16);
      check("reset_y", 32'(bus_a.y), 4);
      check("reset_z", 32'(bus_a.z), 13);
      check("reset_busy", 32'(busy_a), 0);
      check("reset_done", 32'(done_a), 0);
      check("reset_error", 32'(error_a), 0);
      check("reset_cycles", cycles_a, 0);
      check("reset_pulses", 32'({pulse_a, bus_a.wrmem_en_l2}), 0);

      fork
         begin : monitor
            logic wr_prev = 1'b0, done_prev = 1'b0, err_prev = 1'b0;
            int   wr_t = 0, wr_len = 0;
            forever begin
               @(negedge clk);
               if (wr_prev && !bus_a.wrmem_en_l2) emit(EV_WR, wr_t, 32'(wr_len));
               if (bus_a.wrmem_en_l2) begin
                  if (!wr_prev) begin wr_t = tick; wr_len = 0; end
                  wr_len++;
               end
               wr_prev = bus_a.wrmem_en_l2;
               for (int i = 0; i < 4; i++)
                  if (pulse_a[i]) emit(ev_kind_t'(i), tick, 0);
               if (done_a && !done_prev)  emit(EV_DONE, tick, cycles_a);
               if (error_a && !err_prev)  emit(EV_ERR, tick, cycles_a);
               if (!done_a && done_prev)  emit(EV_DONE_CLR, tick, 0);
               if (!error_a && err_prev)  emit(EV_ERR_CLR, tick, 0);
               done_prev = done_a;
               err_prev  = error_a;
            end
         end
         begin : responder
            logic [3:0] armed = '0;
            int         rcnt[4] = '{0, 0, 0, 0};
            forever begin
               @(negedge clk);
               for (int i = 0; i < 4; i++) begin
                  if (pulse_a[i]) begin
                     if (!hold[i]) done_vec[i] = 1'b0;
                     armed[i] = !never[i];
                     rcnt[i]  = 0;
                  end else if (armed[i]) begin
                     rcnt[i]++;
                     if (rcnt[i] == 5) begin
                        done_vec[i] = 1'b1;
                        armed[i]    = 1'b0;
                     end
                  end
               end
            end
         end
      join_none

      // Full run; cfg is zeroed mid-run and x/y/z must not follow it.
      {cfg_x, cfg_y, cfg_z} = {8'd16, 8'd4, 8'd13};
      start = 1'b1; base = tick + 1;
      expect_run(base, {8'd16, 8'd4, 8'd13}, 0, 6);
      @(negedge clk); start = 1'b0;
      wait_until(base + 5);
      {cfg_x, cfg_y, cfg_z} = '0;
      wait_until(base + 30);

      // New cfg is loaded; done_pe_l1 stays high from the last run and must be ignored in its pulse cycle.
      {cfg_x, cfg_y, cfg_z} = {8'd7, 8'd3, 8'd5};
      hold[1] = 1'b1;
      start = 1'b1; base = tick + 1;
      expect_run(base, {8'd7, 8'd3, 8'd5}, 1, 2);
      @(negedge clk); start = 1'b0;
      wait_until(base + 26);
      hold[1] = 1'b0;

      // start pulsed in PE_L2 is ignored; start held across DONE launches the next run one cycle later.
      {cfg_x, cfg_y, cfg_z} = {8'd1, 8'd2, 8'd3};
      start = 1'b1; base = tick + 1;
      expect_run(base, {8'd1, 8'd2, 8'd3}, 1, 6);
      expect_run(base + 26, {8'd4, 8'd5, 8'd6}, 1, 6);
      @(negedge clk); start = 1'b0;
      wait_until(base + 20);
      start = 1'b1; {cfg_x, cfg_y, cfg_z} = {8'd4, 8'd5, 8'd6};
      @(negedge clk); start = 1'b0;
      wait_until(base + 23);
      start = 1'b1;
      wait_until(base + 26);
      start = 1'b0;
      wait_until(base + 56);

      // done_mem_l2 never arrives: error 20 cycles after MEM_L2 entry.
      never[2] = 1'b1;
      {cfg_x, cfg_y, cfg_z} = {8'd2, 8'd2, 8'd2};
      start = 1'b1; base = tick + 1;
      expect_ev(EV_MEM_L1,   base,      0,  24'h020202, 1'b1);
      expect_ev(EV_DONE_CLR, base,      0,  24'h020202, 1'b1);
      expect_ev(EV_PE_L1,    base + 6,  0,  24'h020202, 1'b1);
      expect_ev(EV_WR,       base + 12, 1,  24'h020202, 1'b1);
      expect_ev(EV_MEM_L2,   base + 13, 0,  24'h020202, 1'b1);
      expect_ev(EV_ERR,      base + 33, 32, 24'h020202, 1'b0);
      @(negedge clk); start = 1'b0;
      wait_until(base + 40);
      never[2] = 1'b0;

      // A start from ERR clears error and runs normally.
      {cfg_x, cfg_y, cfg_z} = {8'd3, 8'd3, 8'd3};
      start = 1'b1; base = tick + 1;
      expect_run(base, 24'h030303, 2, 6);
      @(negedge clk); start = 1'b0;
      wait_until(base + 30);

      // Reset in the middle of a 4-cycle write-back.
      {cfg_bx, cfg_by, cfg_bz} = {8'd9, 8'd9, 8'd9};
      start_b = 1'b1; base = tick + 1;
      @(negedge clk); start_b = 1'b0;
      wait_until(base + 5);
      check("wr_b_active", 32'(bus_b.wrmem_en_l2), 1);
      check("wr_b_x_latched", 32'(bus_b.x), 9);
      check("wr_b_cycles", cycles_b, 5);
      rst_b = 1'b1;
      @(negedge clk);
      check("rst_b_wrmem", 32'(bus_b.wrmem_en_l2), 0);
      check("rst_b_busy", 32'(busy_b), 0);
      check("rst_b_x", 32'(bus_b.x), 16);
      check("rst_b_y", 32'(bus_b.y), 4);
      check("rst_b_z", 32'(bus_b.z), 13);
      check("rst_b_cycles", cycles_b, 0);
      check("rst_b_flags", 32'({done_b, error_b}), 0);
      rst_b = 1'b0;
      @(negedge clk);

      check("events_outstanding", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
